min2_scan_ctrl: RTL and testbench
=================================

Name: min2_scan_ctrl

Overview:
- Sequential controller for the smallest-two search over a 16-entry nibble array.
- Input side: accepts the array one element per beat over a valid/ready handshake and buffers it locally.
- Scan phase: one element per cycle through a single shared compare/update stage.
- Output side: presents min1, min2 and index_min1 on a valid/ready handshake.
- Replaces the fully combinational tree when the array arrives serially, for example from a FIFO or bus.

Parameters:
- N, 16, number of elements per array (N >= 2).
- W, 4, element width in bits.
- IW, 4, index width in bits (2^IW >= N).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; returns the block to LOAD.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts a beat (high only in LOAD).
- in_data  input  W  element; the k-th accepted beat is array index k.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- min1  output  W  smallest value.
- min2  output  W  second-smallest value; equals min1 if the minimum is duplicated.
- index_min1  output  IW  lowest index holding min1.
- busy  output  1  high in SCAN or OUT.

Behaviour:
- Reset values (asynchronous):
  - State LOAD; load/scan counter 0.
  - out_valid 0; min1, min2, index_min1 all 0.
  - busy 0; in_ready 1; buffer contents don't-care.
- LOAD state:
  - in_ready = 1.
  - On in_valid & in_ready, write in_data to buffer[cnt] and increment cnt.
  - The beat with cnt == N-1 moves the block to SCAN and clears cnt.
- SCAN state, setup on entry:
  - m1 = m2 = all-ones; idx = 0.
- SCAN state, for each i = 0..N-1, one per cycle, with v = buffer[i]:
  - If v < m1: m2 <= m1, m1 <= v, idx <= i.
  - Else if v < m2: m2 <= v.
  - Comparisons are unsigned and strict, which gives lowest-index tie-break for min1 and min2 == min1 on duplicates.
  - All-ones array gives min1 = min2 = all-ones, index 0.
- SCAN exit:
  - After i = N-1 is processed, load min1, min2 and index_min1 from the working registers.
  - Set out_valid and go to OUT.
- Latency: last input beat accepted in cycle T → out_valid high in cycle T+N+1.
- OUT state:
  - out_valid = 1; outputs are stable.
  - in_ready = 0; input beats are ignored and not consumed.
  - On out_valid & out_ready: next cycle out_valid = 0 and state is LOAD.
  - Result registers hold their last values until overwritten by the next SCAN exit.
- Handshake: out_valid, once high, never drops without out_ready, except on flush or reset.
- busy = (state == SCAN) | (state == OUT).
- flush:
  - Highest priority, synchronous, effective in any state.
  - Next cycle: state LOAD, cnt 0, out_valid 0, result registers 0.
  - A beat presented in the same cycle as flush is not accepted (in_ready is forced 0 when flush = 1).
- rst_n low mid-operation:
  - Immediate return to the reset values.
  - Partial loads and scans are discarded.
- Unused state encodings recover to LOAD.

Test Plan:
- Load {2,3,1,2,5,6,9,9,9,9,9,9,9,9,9,9} with in_valid held high, out_ready = 1 → out_valid exactly 17 cycles after the last beat; min1 = 1, min2 = 2, index_min1 = 2.
- Load {1,4,2,1,2,12,9×10} → min1 = 1, min2 = 1, index_min1 = 0 (duplicate minimum, lowest index wins).
- Load {5,2,10,0,4,1,9×10} with random in_valid gaps → min1 = 0, min2 = 1, index_min1 = 3; in_ready low throughout SCAN and OUT.
- All 16 elements = 15, then out_ready held low 5 cycles → min1 = 15, min2 = 15, index_min1 = 0; outputs and out_valid stable for all 5 cycles; in_ready = 0 and extra in_valid beats are not consumed; after acceptance in_ready = 1 the next cycle.
- flush after 7 accepted beats, then a full new array {15,…,15,0 at index 15} → min1 = 0, min2 = 15, index_min1 = 15; the pre-flush beats have no effect.
- rst_n pulsed low at SCAN index 8 → all outputs 0 and in_ready = 1 immediately; a subsequent full load produces correct results.

Source files
------------

// File: rtl/min2_scan_ctrl.sv
// min2_scan_ctrl
//   Serial smallest-two search over an N-entry array of W-bit elements.
//   The array arrives one element per beat on a valid/ready input and is
//   buffered locally. It is then scanned one element per cycle through a
//   single compare/update stage. The result (min1, min2, index_min1) is held
//   on a valid/ready output until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort back to LOAD (highest priority)
//   in_valid   in_data valid
//   in_ready   block accepts a beat (LOAD only, never while flush is high)
//   in_data    element; the k-th accepted beat is array index k
//   out_valid  result valid (OUT state)
//   out_ready  consumer accepts the result
//   min1       smallest value
//   min2       second-smallest value (equals min1 on a duplicated minimum)
//   index_min1 lowest index holding min1
//   busy       high in SCAN or OUT
module min2_scan_ctrl #(
  parameter int N  = 16,
  parameter int W  = 4,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  min1,
  output logic [W-1:0]  min2,
  output logic [IW-1:0] index_min1,
  output logic          busy
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [W-1:0]  ONES = '1;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SCAN = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] cnt;
  logic          cnt_last;
  logic          load_fire;
  logic [W-1:0]  buffer [N];

  logic [W-1:0]  m1_p0, m2_p0;
  logic [IW-1:0] idx_p0;
  logic [W-1:0]  m1_nxt, m2_nxt;
  logic [IW-1:0] idx_nxt;

  // One compare/update step. Strict unsigned compares keep the lowest index
  // for min1 and let a repeated minimum fall through into min2.
  function automatic logic [2*W+IW-1:0] scan_step(
    input logic [W-1:0]  v,
    input logic [W-1:0]  m1,
    input logic [W-1:0]  m2,
    input logic [IW-1:0] idx,
    input logic [IW-1:0] i
  );
    logic [W-1:0]  n1, n2;
    logic [IW-1:0] ni;
    n1 = m1;
    n2 = m2;
    ni = idx;
    if (v < m1) begin
      n2 = m1;
      n1 = v;
      ni = i;
    end else if (v < m2) begin
      n2 = v;
    end
    return {n1, n2, ni};
  endfunction

  assign cnt_last  = (cnt == LAST);
  assign load_fire = in_valid && in_ready;
  assign {m1_nxt, m2_nxt, idx_nxt} = scan_step(buffer[cnt], m1_p0, m2_p0, idx_p0, cnt);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_nxt;
  end

  // Next-state logic; unused encodings fall back to LOAD
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_LOAD;
    end else begin
      case (state)
        S_LOAD:  if (load_fire && cnt_last) state_nxt = S_SCAN;
        S_SCAN:  if (cnt_last) state_nxt = S_OUT;
        S_OUT:   if (out_ready) state_nxt = S_LOAD;
        default: state_nxt = S_LOAD;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (state == S_LOAD) && !flush;
    out_valid = (state == S_OUT);
    busy      = (state == S_SCAN) || (state == S_OUT);
  end

  // Shared load/scan counter: beat index in LOAD, element index in SCAN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (load_fire || (state == S_SCAN)) begin
      cnt <= cnt_last ? '0 : cnt + 1'b1;
    end else if (state != S_LOAD) begin
      cnt <= '0;
    end
  end

  // Input buffer
  always_ff @(posedge clk) begin
    if (load_fire) buffer[cnt] <= in_data;
  end

  // p0: scan working registers, seeded on the final load beat
  always_ff @(posedge clk) begin
    if (load_fire && cnt_last) begin
      m1_p0  <= ONES;
      m2_p0  <= ONES;
      idx_p0 <= '0;
    end else if (state == S_SCAN) begin
      m1_p0  <= m1_nxt;
      m2_p0  <= m2_nxt;
      idx_p0 <= idx_nxt;
    end
  end

  // Result registers: take the final step's values directly at scan exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min1       <= '0;
      min2       <= '0;
      index_min1 <= '0;
    end else if (flush) begin
      min1       <= '0;
      min2       <= '0;
      index_min1 <= '0;
    end else if ((state == S_SCAN) && cnt_last) begin
      min1       <= m1_nxt;
      min2       <= m2_nxt;
      index_min1 <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_min2_scan_ctrl.sv
module tb_min2_scan_ctrl;

  localparam int N = 16;
  localparam int W = 4;
  localparam int IW = 4;

  typedef logic [W-1:0] arr_t [N];
  typedef struct {
    int m1;
    int m2;
    int idx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]  in_data, min1, min2;
  logic [IW-1:0] index_min1;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t sb[$];

  arr_t a1 = '{2, 3, 1, 2, 5, 6, 9, 9, 9, 9, 9, 9, 9, 9, 9, 9};
  arr_t a2 = '{1, 4, 2, 1, 2, 12, 9, 9, 9, 9, 9, 9, 9, 9, 9, 9};
  arr_t a3 = '{5, 2, 10, 0, 4, 1, 9, 9, 9, 9, 9, 9, 9, 9, 9, 9};
  arr_t a4 = '{15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15};
  arr_t a5 = '{15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 0};

  min2_scan_ctrl #(.N(N), .W(W), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .min1(min1), .min2(min2), .index_min1(index_min1), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference: sort the multiset; min1/min2 are the two smallest entries,
  // index is the first position holding the minimum.
  function automatic exp_t model(input arr_t a);
    int   q[$];
    exp_t e;
    for (int k = 0; k < N; k++) q.push_back(int'(a[k]));
    q.sort();
    e.m1  = q[0];
    e.m2  = q[1];
    e.idx = -1;
    for (int k = 0; k < N; k++) if (e.idx < 0 && int'(a[k]) == e.m1) e.idx = k;
    return e;
  endfunction

  // Monitor: compare every accepted result against the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        flag_fail("unexpected_result");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("min1", int'(min1), e.m1);
        chk("min2", int'(min2), e.m2);
        chk("index_min1", int'(index_min1), e.idx);
      end
    end
  end

  // Called just after a posedge; returns just after a posedge.
  task automatic send(input arr_t a, input int n, input bit gaps, output int acc_cyc);
    bit ok;
    int t;
    acc_cyc = -1;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = a[k];
      ok = 1'b0;
      t  = 0;
      while (!ok) begin
        @(negedge clk);
        ok = in_ready;
        if (ok) acc_cyc = cyc;
        @(posedge clk);
        #1;
        if (!ok && ++t > 200) begin
          flag_fail("send_accept");
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    if (n == N) sb.push_back(model(a));
  endtask

  // Waits for out_valid; every cycle before it must be a SCAN cycle.
  task automatic wait_valid(output int v_cyc);
    int t = 0;
    v_cyc = -1;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        v_cyc = cyc;
        return;
      end
      chk("scan_in_ready", int'(in_ready), 0);
      chk("scan_busy", int'(busy), 1);
      if (++t > 100) begin
        flag_fail("wait_out_valid");
        return;
      end
    end
  endtask

  initial begin
    int   lc, vc;
    arr_t ra;
    bit   done, stalled;
    int   pm1;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_min1", int'(min1), 0);
    chk("rst_min2", int'(min2), 0);
    chk("rst_index", int'(index_min1), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back load, latency from last presented beat
    out_ready = 1'b1;
    send(a1, N, 1'b0, lc);
    wait_valid(vc);
    chk("latency", vc - lc, 17);
    @(posedge clk);
    #1;
    chk("post_accept_valid", int'(out_valid), 0);
    chk("post_accept_ready", int'(in_ready), 1);

    // Duplicated minimum
    send(a2, N, 1'b0, lc);
    wait_valid(vc);
    @(posedge clk);
    #1;

    // Gapped input
    send(a3, N, 1'b1, lc);
    wait_valid(vc);
    @(posedge clk);
    #1;

    // All ones with output backpressure and extra input beats
    out_ready = 1'b0;
    send(a4, N, 1'b0, lc);
    wait_valid(vc);
    in_valid = 1'b1;
    in_data  = 4'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_min1", int'(min1), 15);
      chk("stall_min2", int'(min2), 15);
      chk("stall_index", int'(index_min1), 0);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_valid", int'(out_valid), 0);

    // Flush after 7 beats, beat in the flush cycle refused
    for (int k = 0; k < N; k++) ra[k] = 4'($urandom_range(0, 15));
    send(ra, 7, 1'b0, lc);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 4'd0;
    @(negedge clk);
    chk("flush_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", int'(out_valid), 0);
    chk("flush_min1", int'(min1), 0);
    chk("flush_min2", int'(min2), 0);
    chk("flush_busy", int'(busy), 0);
    send(a5, N, 1'b0, lc);
    wait_valid(vc);
    @(posedge clk);
    #1;

    // Asynchronous reset at scan index 8
    for (int k = 0; k < N; k++) ra[k] = 4'($urandom_range(1, 15));
    send(ra, N, 1'b0, lc);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_min1", int'(min1), 0);
    chk("arst_min2", int'(min2), 0);
    chk("arst_index", int'(index_min1), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) ra[k] = 4'($urandom_range(0, 15));
    send(ra, N, 1'b0, lc);
    wait_valid(vc);
    @(posedge clk);
    #1;

    // Randomized arrays with input gaps and output backpressure
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < N; k++)
        ra[k] = (r % 2 == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      send(ra, N, 1'b1, lc);
      done = 1'b0;
      stalled = 1'b0;
      pm1 = 0;
      for (int t = 0; t < 100 && !done; t++) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (stalled) begin
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_min1", int'(min1), pm1);
        end
        if (out_valid && out_ready) done = 1'b1;
        stalled = out_valid && !out_ready;
        pm1 = int'(min1);
        @(posedge clk);
        #1;
      end
      if (!done) flag_fail("drain_result");
    end

    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
